// File: rtl/music_addr_seq.sv
// ROM address sequencer for multi-track music playback: steps through a track on note ticks,
// stops or loops at END_CODE. Optional loop counter output enabled by `define MUSIC_LOOP_CNT_EN.
//
// state  | meaning
// S_IDLE | stopped, rom_addr held
// S_FETCH| rom_addr just changed, waiting one cycle for ROM read data
// S_PLAY | rom_data valid for rom_addr, advance on step/pending
// S_DONE | non-loop terminator reached, waiting for start/stop
module music_addr_seq #(
   parameter int                           ADDR_W     = 9,
   parameter int                           DATA_W     = 12,
   parameter int                           NUM_TRACKS = 4,
   parameter int                           SEL_W      = 2,
   parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_BASE = {9'd384, 9'd256, 9'd128, 9'd0},
   parameter logic [DATA_W-1:0]            END_CODE   = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [SEL_W-1:0]  i_track_sel,
   input  logic              i_loop_en,
   input  logic              i_step,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic [DATA_W-1:0] o_note,
   output logic              o_note_valid,
   output logic              o_playing,
   output logic              o_done
`ifdef MUSIC_LOOP_CNT_EN
   ,
   output logic [7:0]        o_loop_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [ADDR_W-1:0] r_base;
   logic              r_pending;
   logic              r_done;
   logic [SEL_W-1:0]  w_track_idx;
   logic [ADDR_W-1:0] w_base;
   logic              w_end;
   logic              w_adv;
`ifdef MUSIC_LOOP_CNT_EN
   logic [7:0]        r_loop_cnt;
`endif

   // Out-of-range track selections fall back to track 0.
   always_comb begin
      w_track_idx = i_track_sel;
      if (int'(i_track_sel) >= NUM_TRACKS) w_track_idx = '0;
   end

   assign w_base = TRACK_BASE[int'(w_track_idx)*ADDR_W +: ADDR_W];
   assign w_end  = (i_rom_data == END_CODE);
   assign w_adv  = i_step | r_pending;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_stop)       w_state_nxt = S_IDLE;
      else if (i_start) w_state_nxt = S_FETCH;
      else begin
         case (r_state)
            S_FETCH: w_state_nxt = S_PLAY;
            S_PLAY: begin
               if (w_adv) begin
                  if (!w_end || i_loop_en) w_state_nxt = S_FETCH;
                  else                     w_state_nxt = S_DONE;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      o_playing    = (r_state == S_FETCH) || (r_state == S_PLAY);
      o_note_valid = (r_state == S_PLAY) && !w_end;
   end

   // A step arriving during FETCH is remembered and applied on the first PLAY cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rom_addr <= '0;
         r_base     <= '0;
         r_pending  <= 1'b0;
         r_done     <= 1'b0;
`ifdef MUSIC_LOOP_CNT_EN
         r_loop_cnt <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (i_stop) begin
            r_pending <= 1'b0;
         end else if (i_start) begin
            r_base     <= w_base;
            r_rom_addr <= w_base;
            r_pending  <= 1'b0;
`ifdef MUSIC_LOOP_CNT_EN
            r_loop_cnt <= '0;
`endif
         end else begin
            case (r_state)
               S_FETCH: r_pending <= r_pending | i_step;
               S_PLAY: begin
                  if (w_adv) begin
                     r_pending <= 1'b0;
                     if (!w_end) begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                     end else if (i_loop_en) begin
                        r_rom_addr <= r_base;
`ifdef MUSIC_LOOP_CNT_EN
                        if (r_loop_cnt != 8'hFF) r_loop_cnt <= r_loop_cnt + 8'd1;
`endif
                     end else begin
                        r_done <= 1'b1;
                     end
                  end
               end
               default: r_pending <= r_pending;
            endcase
         end
      end
   end

   assign o_rom_addr = r_rom_addr;
   assign o_note     = i_rom_data;
   assign o_done     = r_done;
`ifdef MUSIC_LOOP_CNT_EN
   assign o_loop_cnt = r_loop_cnt;
`endif

endmodule

// File: tb/tb_music_addr_seq.sv
// Bench for music_addr_seq: directed scenarios then random start/stop/step traffic,
// every cycle compared against a playback-position model driven by a synchronous ROM array.
module tb_music_addr_seq;

   localparam int P_IDLE  = 0;
   localparam int P_FETCH = 1;
   localparam int P_PLAY  = 2;
   localparam int P_DONE  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  sel = '0;
   logic        loop_en = 1'b0;
   logic        step = 1'b0;
   logic [11:0] rom_data = '0;
   logic [8:0]  rom_addr;
   logic [11:0] note;
   logic        note_valid;
   logic        playing;
   logic        done;
`ifdef MUSIC_LOOP_CNT_EN
   logic [7:0]  loop_cnt;
`endif

   logic [11:0] rom [0:511];
   int          base_tab [4] = '{0, 128, 511, 384};

   int n_checks = 0;
   int n_pass   = 0;

   int m_phase = P_IDLE;
   int m_addr  = 0;
   int m_base  = 0;
   int m_lc    = 0;
   bit m_pend  = 0;
   bit m_done  = 0;

   music_addr_seq #(
      .TRACK_BASE({9'd384, 9'd511, 9'd128, 9'd0})
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_stop      (stop),
      .i_track_sel (sel),
      .i_loop_en   (loop_en),
      .i_step      (step),
      .i_rom_data  (rom_data),
      .o_rom_addr  (rom_addr),
      .o_note      (note),
      .o_note_valid(note_valid),
      .o_playing   (playing),
      .o_done      (done)
`ifdef MUSIC_LOOP_CNT_EN
      ,
      .o_loop_cnt  (loop_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic model_step();
      m_done = 0;
      if (rst) begin
         m_phase = P_IDLE; m_addr = 0; m_base = 0; m_pend = 0; m_lc = 0;
      end else if (stop) begin
         m_phase = P_IDLE; m_pend = 0;
      end else if (start) begin
         m_base = base_tab[sel]; m_addr = m_base; m_pend = 0; m_lc = 0; m_phase = P_FETCH;
      end else if (m_phase == P_FETCH) begin
         if (step) m_pend = 1;
         m_phase = P_PLAY;
      end else if (m_phase == P_PLAY && (step || m_pend)) begin
         m_pend = 0;
         if (rom[m_addr] != 12'd0) begin
            m_addr = (m_addr + 1) % 512; m_phase = P_FETCH;
         end else if (loop_en) begin
            m_addr = m_base; m_phase = P_FETCH;
            if (m_lc < 255) m_lc++;
         end else begin
            m_phase = P_DONE; m_done = 1;
         end
      end
   endtask

   task automatic compare_all();
      bit exp_valid;
      exp_valid = (m_phase == P_PLAY) && (rom[m_addr] != 12'd0);
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("playing", 32'(playing), 32'(m_phase == P_FETCH || m_phase == P_PLAY));
      chk("note_valid", 32'(note_valid), 32'(exp_valid));
      chk("done", 32'(done), 32'(m_done));
      if (exp_valid) chk("note", 32'(note), 32'(rom[m_addr]));
`ifdef MUSIC_LOOP_CNT_EN
      chk("loop_cnt", 32'(loop_cnt), 32'(m_lc));
`endif
   endtask

   task automatic cyc(input bit r, input bit sp, input bit st, input logic [1:0] s,
                      input bit lp, input bit stp);
      rst = r; stop = sp; start = st; sel = s; loop_en = lp; step = stp;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      for (int i = 0; i < 512; i++)
         rom[i] = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      rom[128] = 12'd5; rom[129] = 12'd7; rom[130] = 12'd0;
      rom[511] = 12'd9; rom[0] = 12'd3; rom[1] = 12'd4; rom[2] = 12'd0;

      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_nvalid", 32'(note_valid), 32'd0);

      // Track 1, no loop: 5, 7, terminator.
      cyc(0, 0, 1, 1, 0, 0);
      chk("t1_base", 32'(rom_addr), 32'd128);
      cyc(0, 0, 0, 1, 0, 0);
      chk("t1_note5", 32'(note), 32'd5);
      cyc(0, 0, 0, 1, 0, 1);
      chk("t1_addr129", 32'(rom_addr), 32'd129);
      cyc(0, 0, 0, 1, 0, 0);
      chk("t1_note7", 32'(note), 32'd7);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 0);
      chk("t1_end_nvalid", 32'(note_valid), 32'd0);
      cyc(0, 0, 0, 1, 0, 1);
      chk("t1_done_pulse", 32'(done), 32'd1);
      cyc(0, 0, 0, 1, 0, 0);
      chk("t1_done_clear", 32'(done), 32'd0);
      chk("t1_done_addr", 32'(rom_addr), 32'd130);
      cyc(0, 0, 0, 1, 0, 1);
      chk("t1_done_hold", 32'(rom_addr), 32'd130);

      // Same track, looping.
      cyc(0, 0, 1, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 1, 0);
         cyc(0, 0, 0, 1, 1, 1);
      end
      chk("loop_addr", 32'(rom_addr), 32'd128);
      chk("loop_playing", 32'(playing), 32'd1);
`ifdef MUSIC_LOOP_CNT_EN
      chk("loop_cnt1", 32'(loop_cnt), 32'd1);
`endif

      // Step during FETCH must be kept.
      cyc(0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 1);
      cyc(0, 0, 0, 1, 1, 0);
      chk("pend_addr", 32'(rom_addr), 32'd129);
      cyc(0, 0, 0, 1, 1, 0);
      chk("pend_once", 32'(rom_addr), 32'd129);

      // Stop beats start.
      cyc(0, 1, 1, 2, 1, 0);
      chk("stopwin_playing", 32'(playing), 32'd0);
      cyc(0, 0, 1, 3, 1, 0);
      chk("trk3_base", 32'(rom_addr), 32'd384);

      // Wrap from 511, then reset mid-play.
      cyc(0, 0, 1, 2, 0, 0);
      chk("wrap_base", 32'(rom_addr), 32'd511);
      cyc(0, 0, 0, 2, 0, 0);
      cyc(0, 0, 0, 2, 0, 1);
      chk("wrap_0", 32'(rom_addr), 32'd0);
      cyc(0, 0, 0, 2, 0, 0);
      cyc(0, 0, 0, 2, 0, 1);
      chk("wrap_1", 32'(rom_addr), 32'd1);
      cyc(0, 0, 0, 2, 0, 0);
      cyc(1, 0, 0, 2, 0, 1);
      chk("midrst_addr", 32'(rom_addr), 32'd0);
      chk("midrst_playing", 32'(playing), 32'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         bit lp;
         lp = loop_en;
         if ($urandom_range(0, 49) == 0) lp = ~lp;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)), lp,
             ($urandom_range(0, 2) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
